// File: rtl/cond_pkg.sv
// Shared types and constants for the execute-stage condition unit:
// condition codes, flag bit positions and flag-write group selectors.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Bit positions inside the flag vector (order V,C,N,Z from MSB).
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // FlagWE bits: one selects the N/Z pair, the other the C/V pair.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage : cond_pkg

// File: rtl/cond_unit_if.sv
// Execute-stage control bundle between the pipeline (master) and the
// condition unit (slave).
interface cond_unit_if #(
  parameter int FLAG_W = 4,
  parameter int CNT_W  = 16
) ();

  logic              StallE;
  logic              FlushE;
  logic              ValidE;
  logic [3:0]        CondE;
  logic [1:0]        FlagWE;
  logic [FLAG_W-1:0] ALUFlags;
  logic              RegWE;
  logic              MemWE;
  logic              PCSE;
  logic              BranchE;

  logic              CondExE;
  logic [FLAG_W-1:0] Flags;
  logic              RegWM;
  logic              MemWM;
  logic              PCSrcM;
  logic [CNT_W-1:0]  SquashCnt;

  modport master (
    output StallE, FlushE, ValidE, CondE, FlagWE, ALUFlags,
           RegWE, MemWE, PCSE, BranchE,
    input  CondExE, Flags, RegWM, MemWM, PCSrcM, SquashCnt
  );

  modport slave (
    input  StallE, FlushE, ValidE, CondE, FlagWE, ALUFlags,
           RegWE, MemWE, PCSE, BranchE,
    output CondExE, Flags, RegWM, MemWM, PCSrcM, SquashCnt
  );

endinterface : cond_unit_if

// File: rtl/cond_check.sv
// Pure combinational evaluation of a 4-bit condition field against the
// architectural flag register.
module cond_check
  import cond_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic [3:0]        CondE,
  input  logic [FLAG_W-1:0] Flags,
  output logic              CondExE
);

  logic v, c, n, z;

  assign v = Flags[FLAG_V];
  assign c = Flags[FLAG_C];
  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    CondExE = 1'b0;
    case (cond_e'(CondE))
      COND_EQ: CondExE = z;
      COND_NE: CondExE = ~z;
      COND_CS: CondExE = c;
      COND_CC: CondExE = ~c;
      COND_MI: CondExE = n;
      COND_PL: CondExE = ~n;
      COND_VS: CondExE = v;
      COND_VC: CondExE = ~v;
      COND_HI: CondExE = c & ~z;
      COND_LS: CondExE = ~c | z;
      COND_GE: CondExE = (n == v);
      COND_LT: CondExE = (n != v);
      COND_GT: CondExE = ~z & (n == v);
      COND_LE: CondExE = z | (n != v);
      COND_AL: CondExE = 1'b1;
      default: CondExE = 1'b0;  // reserved code never executes
    endcase
  end

endmodule : cond_check

// File: rtl/cond_unit.sv
// Execute-stage condition unit: flag register, gated E->M enables and a
// saturating counter of condition-failed instructions.
module cond_unit
  import cond_pkg::*;
#(
  parameter int                FLAG_W      = 4,
  parameter int                CNT_W       = 16,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
  input  logic      clk,
  input  logic      reset,
  cond_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              cond_ex;
  logic              exec;
  logic              squash;

  logic [FLAG_W-1:0] flags_q,      flags_d;
  logic              reg_wm_q,     reg_wm_d;
  logic              mem_wm_q,     mem_wm_d;
  logic              pc_src_m_q,   pc_src_m_d;
  logic [CNT_W-1:0]  squash_cnt_q, squash_cnt_d;

  // Condition is judged on the registered flags, so a flag write at one edge
  // is already visible to the instruction that enters E at that same edge.
  cond_check #(.FLAG_W(FLAG_W)) u_check (
    .CondE   (bus.CondE),
    .Flags   (flags_q),
    .CondExE (cond_ex)
  );

  assign exec   = bus.ValidE &  cond_ex & ~bus.StallE & ~bus.FlushE;
  assign squash = bus.ValidE & ~cond_ex & ~bus.StallE & ~bus.FlushE;

  always_comb begin
    flags_d = flags_q;
    if (exec && bus.FlagWE[FLAGW_NZ]) begin
      flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
    end
    if (exec && bus.FlagWE[FLAGW_CV]) begin
      flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
      flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
    end
  end

  // Flush inserts a bubble and outranks stall; stall freezes the boundary.
  always_comb begin
    reg_wm_d   = reg_wm_q;
    mem_wm_d   = mem_wm_q;
    pc_src_m_d = pc_src_m_q;
    if (bus.FlushE) begin
      reg_wm_d   = 1'b0;
      mem_wm_d   = 1'b0;
      pc_src_m_d = 1'b0;
    end else if (!bus.StallE) begin
      reg_wm_d   = bus.RegWE & exec;
      mem_wm_d   = bus.MemWE & exec;
      pc_src_m_d = (bus.PCSE | bus.BranchE) & exec;
    end
  end

  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (squash && (squash_cnt_q != CNT_MAX))
      squash_cnt_d = squash_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      flags_q      <= RESET_FLAGS;
      reg_wm_q     <= 1'b0;
      mem_wm_q     <= 1'b0;
      pc_src_m_q   <= 1'b0;
      squash_cnt_q <= '0;
    end else begin
      flags_q      <= flags_d;
      reg_wm_q     <= reg_wm_d;
      mem_wm_q     <= mem_wm_d;
      pc_src_m_q   <= pc_src_m_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign bus.CondExE   = cond_ex;
  assign bus.Flags     = flags_q;
  assign bus.RegWM     = reg_wm_q;
  assign bus.MemWM     = mem_wm_q;
  assign bus.PCSrcM    = pc_src_m_q;
  assign bus.SquashCnt = squash_cnt_q;

endmodule : cond_unit
